// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op identifier.
// Holds the op-code encoding (same as the logic unit select), the FSM state
// type and two small mask helpers used when narrowing the candidate set.
package logic_op_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    RESULT  = 2'b10
  } state_t;

  // Number of ops still consistent in a candidate mask
  function automatic logic [2:0] popCount4(input logic [3:0] mask);
    popCount4 = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
  endfunction

  // Index of the single set bit; only meaningful when exactly one bit is set
  function automatic logic [1:0] onehotIndex(input logic [3:0] mask);
    case (mask)
      4'b0001: onehotIndex = OP_AND;
      4'b0010: onehotIndex = OP_OR;
      4'b0100: onehotIndex = OP_XOR;
      4'b1000: onehotIndex = OP_XNOR;
      default: onehotIndex = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/logic_op_match.sv
// Combinational match vector for one observed (a, b, d) triple.
// Bit k of m is set when op k applied to a and b reproduces d on every bit.
// Ports:
//   a, b : observed operands
//   d    : observed result
//   m    : per-op match flags, indexed by op code
module logic_op_match
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       m
);

  assign m[OP_AND]  = ((a & b) == d);
  assign m[OP_OR]   = ((a | b) == d);
  assign m[OP_XOR]  = ((a ^ b) == d);
  assign m[OP_XNOR] = (~(a ^ b) == d);

endmodule

// File: rtl/logic_op_identifier.sv
// Identifies which of AND/OR/XOR/XNOR produced a stream of observed
// (a, b, d) triples. Each accepted sample removes the ops it contradicts
// from the candidate mask; the verdict is issued once one op remains, none
// remain, or the sample budget runs out with several still alive.
// Ports:
//   clk, rst          : clock and async active-high reset
//   start             : pulse that begins (or restarts) an identification
//   in_valid/in_ready : sample handshake for a/b/d
//   a, b, d           : observed operands and result
//   busy              : identification in progress
//   done              : one-cycle pulse when the verdict is ready
//   op_id, err        : verdict (op code, failure flag)
//   cand              : live candidate mask
//   sample_cnt        : samples accepted so far
module logic_op_identifier
  import logic_op_pkg::*;
#(
  parameter  int WIDTH       = 4,
  parameter  int MAX_SAMPLES = 8,
  localparam int CNT_W       = $clog2(MAX_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [1:0]       op_id,
  output logic             err,
  output logic [3:0]       cand,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] sampleCnt_q;
  logic [1:0]       opId_q;
  logic             err_q;

  logic [3:0]       matchVec;
  logic [3:0]       nextCand_d;
  logic [CNT_W-1:0] nextCnt_d;
  logic [2:0]       nextPop;
  logic             accept;

  logic_op_match #(.WIDTH(WIDTH)) u_match (
    .a (a),
    .b (b),
    .d (d),
    .m (matchVec)
  );

  // A start pulse blocks acceptance so a colliding sample is dropped
  assign in_ready   = (state_q == COLLECT) & ~start;
  assign accept     = in_valid & in_ready;
  assign nextCand_d = cand_q & matchVec;
  assign nextCnt_d  = sampleCnt_q + CNT_W'(1);
  assign nextPop    = popCount4(nextCand_d);

  // Identification FSM with candidate, counter and verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= 4'b1111;
      sampleCnt_q <= '0;
      opId_q      <= OP_AND;
      err_q       <= 1'b0;
    end else if (start) begin
      state_q     <= COLLECT;
      cand_q      <= 4'b1111;
      sampleCnt_q <= '0;
      opId_q      <= OP_AND;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        COLLECT: begin
          if (accept) begin
            // cand keeps the surviving set so the error cause stays visible
            cand_q      <= nextCand_d;
            sampleCnt_q <= nextCnt_d;
            if (nextPop == 3'd1) begin
              state_q <= RESULT;
              opId_q  <= onehotIndex(nextCand_d);
              err_q   <= 1'b0;
            end else if (nextPop == 3'd0) begin
              state_q <= RESULT;
              opId_q  <= OP_AND;
              err_q   <= 1'b1;
            end else if (nextCnt_d == MAX_CNT) begin
              state_q <= RESULT;
              err_q   <= 1'b1;
            end
          end
        end
        RESULT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q == COLLECT);
  assign done       = (state_q == RESULT);
  assign op_id      = opId_q;
  assign err        = err_q;
  assign cand       = cand_q;
  assign sample_cnt = sampleCnt_q;

endmodule

// File: doc/logic_op_identifier.md
Name: logic_op_identifier

Overview:
- Inverse-direction companion to the 4-function logic unit (AND/OR/XOR/XNOR selected by a 2-bit select).
- Consumes a stream of observed (A, B, result) triples over a valid/ready handshake and narrows down which select code produced them.
- Reports the identified op code, or an error if the triples are inconsistent or stay ambiguous.
- Sits on the test/observation side of the datapath, e.g. behind a trace capture or a self-check harness.

Parameters:
- WIDTH, 4, operand/result width in bits.
- MAX_SAMPLES, 8, maximum accepted samples per identification before declaring ambiguity (>=1).
- CNT_W, derived localparam = $clog2(MAX_SAMPLES+1), sample counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new identification.
- in_valid  input  1  sample present on a/b/d.
- in_ready  output  1  block accepts a sample this cycle.
- a  input  WIDTH  observed operand A.
- b  input  WIDTH  observed operand B.
- d  input  WIDTH  observed result.
- busy  output  1  identification in progress.
- done  output  1  one-cycle pulse when a verdict is ready.
- op_id  output  2  identified op: 00 AND, 01 OR, 10 XOR, 11 XNOR (same encoding as the logic unit select).
- err  output  1  verdict is failure.
- cand  output  4  live candidate mask; bit k set = op k still consistent.
- sample_cnt  output  CNT_W  samples accepted in the current identification.

Behaviour:
- Reset (async, immediate): state IDLE, cand=4'b1111, sample_cnt=0, op_id=00, err=0, done=0, busy=0, in_ready=0. Reset mid-identification discards all progress.
- States: IDLE, COLLECT, RESULT.
- Match vector m[k] = (op_k(a,b) == d), bitwise over all WIDTH bits. XNOR is ~(a^b).
- Handshake: accept = in_valid & in_ready.
- in_ready = (state==COLLECT) & ~start.
- a/b/d sampled only on accept.
- IDLE:
  - start -> COLLECT, cand=1111, sample_cnt=0, err=0, op_id=00.
  - Otherwise hold; op_id/err retain the last verdict.
- COLLECT (busy=1): on accept, next_cand = cand & m, and sample_cnt increments.
  - popcount(next_cand)==1 -> RESULT; op_id = index of the set bit; err=0.
  - next_cand==0 -> RESULT; err=1 (inconsistent); op_id=00.
  - popcount>1 and sample_cnt+1==MAX_SAMPLES -> RESULT; err=1 (ambiguous). cand keeps the surviving set, so the error cause is visible (cand==0 means inconsistent).
  - Otherwise stay in COLLECT; cand=next_cand.
  - No accept -> hold all state.
- RESULT: done=1 for exactly one cycle, busy=0, in_ready=0; then -> IDLE.
- Latency: done is asserted the cycle after the deciding accept. Verdict outputs are registered and stable from the done cycle until the next start.
- start in any non-reset state restarts to COLLECT with cleared cand/count and wins over a same-cycle sample. That sample is not accepted because in_ready is low.
- start coincident with RESULT: done still pulses that cycle; the next state is COLLECT, not IDLE.
- Property: XOR and XNOR are never both set after >=1 sample. AND/OR/XOR all survive a=b=d=0.
- All counters saturate-free by construction: sample_cnt never exceeds MAX_SAMPLES.

Decomposition:
- Shared package logic_op_pkg:
  - op codes OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11.
  - state enum {IDLE, COLLECT, RESULT}.
  - function returning the one-hot index of a 4-bit mask.
- Sub-module logic_op_match: combinational, parameter WIDTH; inputs a, b, d; output m[3:0]. Reusable by the bench scoreboard.
- Top holds the FSM, cand register, counter and verdict registers.

Test Plan:
- Reset during COLLECT after 2 samples -> cand=1111, sample_cnt=0, busy=0, in_ready=0 immediately; no done pulse.
- start; samples (0,0,0), (F,0,F), (F,F,F) -> cand 0111 -> 0110 -> 0010; done the cycle after the 3rd accept; op_id=01, err=0, sample_cnt=3.
- start; single sample (A=C,B=A,D=9) -> XNOR only matches (C^A=6, ~6=9); done after 1 sample; op_id=11, err=0.
- start; (3,5,1) then (3,5,7) -> first gives cand 0001 with op_id=00 immediately; a rerun with (3,5,7) first then (3,5,1) -> cand 0010 then 0000, err=1, cand=0000.
- MAX_SAMPLES=8; start; eight samples of (0,0,0) -> after the 8th accept, err=1, cand=0111, sample_cnt=8; in_valid held high afterwards is not accepted (in_ready=0).
- start asserted in the same cycle as in_valid while in COLLECT with cand=0110 -> sample not accepted, cand=1111, sample_cnt=0. Also back-to-back start during RESULT -> done pulse seen, then busy=1 the next cycle.
